// File: rtl/pc_pkg.sv
// Shared constants and the next-PC source select for the 16-bit core.
package pc_pkg;

  localparam int BUS_WIDTH_DEF = 16;
  localparam int PC_INC        = 1;

  typedef enum logic [2:0] {
    SEL_RST,
    SEL_STALL,
    SEL_RET,
    SEL_CALL,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_SEQ
  } pc_sel_t;

endpackage

// File: rtl/pc_next_unit_if.sv
// Request/response bundle between the decode/branch logic and the next-PC unit.
interface pc_next_unit_if #(
  parameter int BUS_WIDTH = 16,
  parameter int RAS_DEPTH = 8
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [BUS_WIDTH-1:0] pc;
  logic                 stall;
  logic                 branch_taken;
  logic [BUS_WIDTH-1:0] branch_offset;
  logic                 jump;
  logic                 call;
  logic [BUS_WIDTH-1:0] target;
  logic                 ret;
  logic [BUS_WIDTH-1:0] pc_next;
  logic [CW-1:0]        ras_count;
  logic                 ras_err;

  modport master (
    output pc, stall, branch_taken, branch_offset, jump, call, target, ret,
    input  pc_next, ras_count, ras_err
  );

  modport slave (
    input  pc, stall, branch_taken, branch_offset, jump, call, target, ret,
    output pc_next, ras_count, ras_err
  );
endinterface

// File: rtl/pc_next_unit_ras_stack.sv
// Circular return-address stack: a full stack silently overwrites its oldest
// entry on push; a pop of an empty stack is reported and otherwise ignored.
module ras_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  entries_q [DEPTH];
  logic [W-1:0]  entries_d [DEPTH];
  logic          full, empty;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign top_data = entries_q[top_q];
  assign count    = count_q;

  // Next stack state; push and pop are never requested together by the caller.
  always_comb begin
    top_d     = top_q;
    count_d   = count_q;
    entries_d = entries_q;
    overflow  = push && full;
    underflow = pop && empty;
    if (push) begin
      entries_d[top_q + PW'(1)] = push_data;
      top_d                     = top_q + PW'(1);
      if (!full) count_d = count_q + CW'(1);
    end else if (pop && !empty) begin
      top_d   = top_q - PW'(1);
      count_d = count_q - CW'(1);
    end
  end

  // Stack registers with synchronous active-low clear of pointer, count and entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      top_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      top_q     <= top_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC generator feeding the pc register: priority select between reset,
// stall, return, call, jump, branch and sequential, plus the return stack.
// Optional sticky stack error flag enabled by defining PC_NEXT_RAS_ERR_EN.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int RAS_DEPTH = 8,
  parameter int INC       = PC_INC
) (
  input  logic           clk,
  input  logic           rst,
  pc_next_unit_if.slave  bus
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  pc_sel_t              sel;
  logic [BUS_WIDTH-1:0] pc_inc, pc_br, ras_top;
  logic [CW-1:0]        ras_cnt;
  logic                 ras_push, ras_pop, ras_ovf, ras_unf;

  assign pc_inc = bus.pc + BUS_WIDTH'(INC);
  assign pc_br  = bus.pc + bus.branch_offset;

  // Source priority; only the winning request may touch the stack.
  always_comb begin
    sel = SEL_SEQ;
    if (!rst)                  sel = SEL_RST;
    else if (bus.stall)        sel = SEL_STALL;
    else if (bus.ret)          sel = SEL_RET;
    else if (bus.call)         sel = SEL_CALL;
    else if (bus.jump)         sel = SEL_JUMP;
    else if (bus.branch_taken) sel = SEL_BRANCH;
  end

  assign ras_push = (sel == SEL_CALL);
  assign ras_pop  = (sel == SEL_RET);

  // pc_next mux; a return on an empty stack falls through to the sequential address.
  always_comb begin
    bus.pc_next = pc_inc;
    case (sel)
      SEL_RST:    bus.pc_next = '0;
      SEL_STALL:  bus.pc_next = bus.pc;
      SEL_RET:    bus.pc_next = (ras_cnt == '0) ? pc_inc : ras_top;
      SEL_CALL:   bus.pc_next = bus.target;
      SEL_JUMP:   bus.pc_next = bus.target;
      SEL_BRANCH: bus.pc_next = pc_br;
      default:    bus.pc_next = pc_inc;
    endcase
  end

  ras_stack #(.W(BUS_WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .count     (ras_cnt),
    .overflow  (ras_ovf),
    .underflow (ras_unf)
  );

  assign bus.ras_count = ras_cnt;

`ifdef PC_NEXT_RAS_ERR_EN
  logic ras_err_q, ras_err_d;

  // Sticky error: any overflow or underflow holds until reset.
  always_comb begin
    ras_err_d = ras_err_q | ras_ovf | ras_unf;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (!rst) ras_err_q <= 1'b0;
    else      ras_err_q <= ras_err_d;
  end

  assign bus.ras_err = ras_err_q;
`else
  logic unused_ras_flags;
  assign unused_ras_flags = ras_ovf ^ ras_unf;
  assign bus.ras_err      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed plan steps then random traffic, checked
// against a queue-based model of the return stack.
module tb_pc_next_unit;
  localparam int BW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef PC_NEXT_RAS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk, rst;
  pc_next_unit_if #(.BUS_WIDTH(BW), .RAS_DEPTH(DEPTH)) bus ();

  pc_next_unit #(.BUS_WIDTH(BW), .RAS_DEPTH(DEPTH), .INC(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [BW-1:0] ras_q [$];
  bit            err_m;
  logic [BW-1:0] pc_fb;

  task automatic step(input string tag, input logic r, s, rt, c, j, bt,
                      input logic [BW-1:0] p, tgt, off);
    logic [BW-1:0] exp_pc;
    logic          exp_err;
    rst = r; bus.stall = s; bus.ret = rt; bus.call = c; bus.jump = j;
    bus.branch_taken = bt; bus.pc = p; bus.target = tgt; bus.branch_offset = off;
    // expected next PC from the current model state
    if (!r)           exp_pc = '0;
    else if (s)       exp_pc = p;
    else if (rt)      exp_pc = (ras_q.size() == 0) ? p + 16'd1 : ras_q[$];
    else if (c || j)  exp_pc = tgt;
    else if (bt)      exp_pc = p + off;
    else              exp_pc = p + 16'd1;
    #2;
    tests++;
    assert (bus.pc_next === exp_pc) else begin
      fails++;
      $error("FAIL %s pc_next got %h want %h", tag, bus.pc_next, exp_pc);
    end
    @(posedge clk);
    if (!r) begin
      ras_q.delete();
      err_m = 1'b0;
    end else if (!s) begin
      if (rt) begin
        if (ras_q.size() == 0) err_m = 1'b1;
        else void'(ras_q.pop_back());
      end else if (c) begin
        if (ras_q.size() == DEPTH) begin
          void'(ras_q.pop_front());
          err_m = 1'b1;
        end
        ras_q.push_back(p + 16'd1);
      end
    end
    #1;
    exp_err = ERR_EN & err_m;
    tests++;
    assert (bus.ras_count === CW'(ras_q.size())) else begin
      fails++;
      $error("FAIL %s ras_count got %0d want %0d", tag, bus.ras_count, ras_q.size());
    end
    tests++;
    assert (bus.ras_err === exp_err) else begin
      fails++;
      $error("FAIL %s ras_err got %b want %b", tag, bus.ras_err, exp_err);
    end
    pc_fb = exp_pc;
  endtask

  initial begin
    err_m = 1'b0;
    pc_fb = '0;
    // reset, then free-running sequential fetch with pc fed back
    step("rst0", 0,0,0,0,0,0, 16'h1234, 0, 0);
    step("rst1", 0,0,0,0,0,0, 16'h5678, 0, 0);
    for (int i = 0; i < 4; i++) step("seq", 1,0,0,0,0,0, pc_fb, 0, 0);
    tests++;
    assert (pc_fb === 16'h0004) else begin
      fails++;
      $error("FAIL seq_end pc got %h want %h", pc_fb, 16'h0004);
    end
    // branch backwards and increment wrap
    step("br_neg", 1,0,0,0,0,1, 16'h0010, 0, 16'hFFF8);
    step("wrap",   1,0,0,0,0,0, 16'hFFFF, 0, 0);
    step("br_wrap",1,0,0,0,0,1, 16'h0002, 0, 16'hFFFC);
    step("jump",   1,0,0,0,1,1, 16'h0050, 16'h0ABC, 16'h0004);
    // call then return
    step("call",   1,0,0,1,0,0, 16'h0020, 16'h0100, 0);
    step("ret",    1,0,1,0,0,0, 16'h0100, 0, 0);
    // overflow: nine calls, then eight returns
    step("rst_ov", 0,0,0,0,0,0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step("ovf_call", 1,0,0,1,0,0, 16'(16'h10 + i), 16'h0300, 0);
    for (int i = 0; i < 8; i++) begin
      step("ovf_ret", 1,0,1,0,0,0, 16'h0200, 0, 0);
      tests++;
      assert (pc_fb === 16'(16'h19 - i)) else begin
        fails++;
        $error("FAIL ovf_ret_val got %h want %h", pc_fb, 16'(16'h19 - i));
      end
    end
    // underflow after reset
    step("rst_un", 0,0,0,0,0,0, 0, 0, 0);
    step("undf",   1,0,1,0,0,0, 16'h0040, 0, 0);
    // conflicts and stall
    step("stall_call", 1,1,0,1,0,0, 16'h0060, 16'h0700, 0);
    step("push33",     1,0,0,1,0,0, 16'h0032, 16'h0800, 0);
    step("ret_call",   1,0,1,1,0,0, 16'h0090, 16'h0900, 0);
    step("stall_ret",  1,0,0,1,0,0, 16'h0044, 16'h0900, 0);
    step("stall_ret2", 1,1,1,0,0,0, 16'h0900, 0, 0);
    step("push2",      1,0,0,1,0,0, 16'h0900, 16'h0A00, 0);
    step("rst_mid",    0,0,0,1,0,0, 16'h0A00, 16'h0B00, 0);
    step("ret_after",  1,0,1,0,0,0, 16'h0077, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [BW-1:0] p;
      p = ($urandom_range(3) == 0) ? 16'($urandom) : pc_fb;
      step("rand",
           ($urandom_range(39) != 0),
           ($urandom_range(7) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(2) == 0),
           ($urandom_range(7) == 0),
           ($urandom_range(3) == 0),
           p, 16'($urandom), 16'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Next-PC generator sitting directly upstream of the `pc` register in the 16-bit single-cycle processor. Each cycle it selects `pc_next` from the following sources: sequential increment, PC-relative branch, absolute jump, call, or return. It contains a circular return-address stack (RAS) updated on the clock edge that `pc` also uses. Its `pc_next` output drives the `pc` register input directly.

## Interface
Parameters:
- `BUS_WIDTH`, 16, address/data width
- `RAS_DEPTH`, 8, return-address stack entries (power of two, ≥2)
- `INC`, 1, sequential increment (word-addressed instruction memory)

Ports:
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, synchronous, active-low
- `pc` in BUS_WIDTH: current PC from `pc` register
- `stall` in 1: hold PC, no stack change
- `branch_taken` in 1: conditional branch resolved taken
- `branch_offset` in BUS_WIDTH: sign-extended branch offset
- `jump` in 1: absolute jump
- `call` in 1: absolute jump plus push of return address
- `target` in BUS_WIDTH: jump/call destination
- `ret` in 1: return to address at top of stack
- `pc_next` out BUS_WIDTH: next PC, to `pc` register
- `ras_count` out $clog2(RAS_DEPTH)+1: valid entries in the stack
- `ras_err` out 1: sticky overflow/underflow flag

## Operation
- Selection priority, highest first:
  - `rst` low: `pc_next` = 0
  - `stall`: `pc_next` = `pc`
  - `ret`: `pc_next` = stack top, then pop
  - `call`: `pc_next` = `target`, then push `pc`+INC
  - `jump`: `pc_next` = `target`
  - `branch_taken`: `pc_next` = `pc` + `branch_offset`
  - otherwise: `pc_next` = `pc`+INC
- Lower-priority requests in the same cycle are ignored. In particular, `ret` and `call` together means the return wins and there is no push.
- All additions are modulo 2^BUS_WIDTH. Wrap-around is silent: 0xFFFF+1 = 0x0000, and 0x0002+0xFFFC = 0xFFFE.
- Stack state: `top` pointer (index of last push), `ras_count`, and RAS_DEPTH entries.
  - Push writes entry `top+1`, advances `top` (mod RAS_DEPTH), and increments `ras_count` saturating at RAS_DEPTH.
- Overflow is a call with `ras_count`==RAS_DEPTH. It overwrites the oldest entry (circular), `ras_count` stays RAS_DEPTH, and the error is flagged.
- Underflow is a ret with `ras_count`==0.
  - `pc_next` = `pc`+INC.
  - No pop; the pointer and count are unchanged.
  - The error is flagged.
- Stack updates are suppressed while `stall` is high or `rst` is low.

## Timing
- `pc_next` is purely combinational from the inputs and the registered stack top, with zero-cycle latency. The `pc` register captures it on the next rising edge.
- Push, pop, `ras_count` and `ras_err` update on the rising `clk` edge of the request cycle. A `ret` in the cycle after a `call` returns the just-pushed address.
- Reset, while `rst` is low at a rising edge:
  - `top` = 0, `ras_count` = 0, all entries = 0, `ras_err` = 0.
  - `pc_next` reads 0 throughout reset.
- Reset mid-sequence discards all stack contents. The first `ret` after reset underflows.
- Stack reads of an empty stack never reach `pc_next` (the underflow rule applies).

## Configuration
- `PC_NEXT_RAS_ERR_EN` defined: `ras_err` sets on overflow or underflow and holds until reset.
- Macro undefined: `ras_err` is tied to 0 and no flag logic is built. Overflow and underflow behaviour of `pc_next` and the stack is unchanged.

## Structure
- Shared package `pc_pkg`:
  - BUS_WIDTH default and INC constant.
  - `pc_sel_t` enum: `SEL_RST`, `SEL_STALL`, `SEL_RET`, `SEL_CALL`, `SEL_JUMP`, `SEL_BRANCH`, `SEL_SEQ`.
- Sub-module `ras_stack` holds the circular RAS.
  - Inputs: push/pop/data.
  - Outputs: top, count, overflow, underflow.
- `pc_next_unit` keeps the priority select, the adders and the error flag.

## Test plan
- Reset, then release with no requests and `pc` fed back: `pc_next` sequence is 0, 1, 2, 3; `ras_count` = 0.
- At `pc`=0x0010, `branch_taken` with offset 0xFFF8 → `pc_next`=0x0008. At `pc`=0xFFFF with no request → `pc_next`=0x0000.
- Call and return:
  - `call` at `pc`=0x0020 with `target`=0x0100 gives `pc_next`=0x0100 and `ras_count`=1.
  - Next cycle, `ret` gives `pc_next`=0x0021 and `ras_count`=0.
- Overflow with RAS_DEPTH=8:
  - Issue 9 calls from pc 0x10 through 0x18. `ras_count` stays 8 and `ras_err`=1 (macro on).
  - Then issue 8 rets. They return 0x19 down to 0x12, and the oldest entry 0x11 is lost.
- Underflow: `ret` with an empty stack at `pc`=0x0040 → `pc_next`=0x0041, `ras_count` stays 0, `ras_err`=1. With the macro off, `ras_err` stays 0.
- Conflicts and stall:
  - `stall` together with `call` gives `pc_next`=`pc` and no push.
  - `ret` plus `call` with one entry 0x0033 gives `pc_next`=0x0033 and `ras_count`=0.
  - Dropping `rst` mid-stack clears `ras_count` to 0.
